decompress_block_scheduler: RTL

//   Time-multiplexes NUM_ENGINES decompress_block engines over every 8x8 block of an image.

---
 rtl/decompress_block_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/decompress_block_scheduler.sv
// Hands out block coordinates in raster order to a pool of decompress engines and
// round-robin arbitrates finished blocks onto a single writeback port.
module decompress_block_scheduler #(
  parameter int IMG_ROWS        = 480,
  parameter int IMG_COLS        = 640,
  parameter int LOG2_BLOCK_SIZE = 3,
  parameter int NUM_ENGINES     = 4,
  localparam int NBR = IMG_ROWS >> LOG2_BLOCK_SIZE,
  localparam int NBC = IMG_COLS >> LOG2_BLOCK_SIZE,
  localparam int RW  = (NBR > 1) ? $clog2(NBR) : 1,
  localparam int CW  = (NBC > 1) ? $clog2(NBC) : 1,
  localparam int EW  = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_img,
  output logic [NUM_ENGINES-1:0]    eng_start,
  output logic [NUM_ENGINES*RW-1:0] eng_blk_row,
  output logic [NUM_ENGINES*CW-1:0] eng_blk_col,
  input  logic [NUM_ENGINES-1:0]    eng_done,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [EW-1:0]             wb_engine,
  output logic [RW-1:0]             wb_blk_row,
  output logic [CW-1:0]             wb_blk_col,
  output logic                      busy,
  output logic                      img_done
);

  localparam int TOTAL = NBR * NBC;
  localparam int TW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {ENG_FREE, ENG_BUSY, ENG_WB_PEND} eng_state_t;

  state_t     state;
  eng_state_t eng_state [NUM_ENGINES];

  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic [TW-1:0] wb_count;
  logic [EW-1:0] rr_ptr;

  logic [NUM_ENGINES-1:0] free_mask;
  logic [NUM_ENGINES-1:0] pend_mask;
  logic [NUM_ENGINES-1:0] cand_mask;
  logic                   hs;
  logic                   last_blk;
  logic                   disp_en;
  logic                   disp_found;
  logic [EW-1:0]          disp_eng;
  logic                   arb_found;
  logic [EW-1:0]          arb_eng;
  logic [EW-1:0]          arb_base;
  logic [EW-1:0]          arb_idx;
  logic [EW-1:0]          rr_next;

  always_comb begin
    free_mask = '0;
    pend_mask = '0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      free_mask[e] = (eng_state[e] == ENG_FREE);
      pend_mask[e] = (eng_state[e] == ENG_WB_PEND);
    end
  end

  assign hs       = wb_valid && wb_ready;
  assign rr_next  = (int'(wb_engine) == NUM_ENGINES - 1) ? '0 : wb_engine + 1'b1;
  assign last_blk = (row_cnt == RW'(NBR - 1)) && (col_cnt == CW'(NBC - 1));
  // The start-sampling edge already issues block (0,0), giving the one-cycle start latency.
  assign disp_en  = disp_found && ((state == S_IDLE && start_img) || state == S_DISPATCH);

  // Lowest-index engine that is FREE at the start of the cycle.
  always_comb begin
    disp_found = 1'b0;
    disp_eng   = '0;
    for (int e = NUM_ENGINES - 1; e >= 0; e--) begin
      if (free_mask[e]) begin
        disp_found = 1'b1;
        disp_eng   = EW'(e);
      end
    end
  end

  // Round-robin search; on a handshake the departing engine is excluded and the
  // search restarts just past it, so the next grant can be presented back to back.
  always_comb begin
    arb_base  = hs ? rr_next : rr_ptr;
    cand_mask = pend_mask;
    if (hs) cand_mask[wb_engine] = 1'b0;
    arb_found = 1'b0;
    arb_eng   = '0;
    arb_idx   = '0;
    for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
      arb_idx = EW'((int'(arb_base) + k) % NUM_ENGINES);
      if (cand_mask[arb_idx]) begin
        arb_found = 1'b1;
        arb_eng   = arb_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      for (int e = 0; e < NUM_ENGINES; e++) eng_state[e] <= ENG_FREE;
      row_cnt     <= '0;
      col_cnt     <= '0;
      wb_count    <= '0;
      rr_ptr      <= '0;
      eng_start   <= '0;
      eng_blk_row <= '0;
      eng_blk_col <= '0;
      wb_valid    <= 1'b0;
      wb_engine   <= '0;
      wb_blk_row  <= '0;
      wb_blk_col  <= '0;
      busy        <= 1'b0;
      img_done    <= 1'b0;
    end else begin
      eng_start <= '0;
      img_done  <= 1'b0;

      for (int e = 0; e < NUM_ENGINES; e++) begin
        if (eng_state[e] == ENG_BUSY && eng_done[e]) eng_state[e] <= ENG_WB_PEND;
      end

      if (hs) begin
        eng_state[wb_engine] <= ENG_FREE;
        wb_count             <= wb_count + 1'b1;
        rr_ptr               <= rr_next;
      end

      if (!wb_valid || hs) begin
        wb_valid <= arb_found;
        if (arb_found) begin
          wb_engine  <= arb_eng;
          wb_blk_row <= eng_blk_row[arb_eng*RW +: RW];
          wb_blk_col <= eng_blk_col[arb_eng*CW +: CW];
        end
      end

      case (state)
        S_IDLE: begin
          if (start_img) begin
            state <= S_DISPATCH;
            busy  <= 1'b1;
          end
        end
        S_DISPATCH: ;
        S_DRAIN: begin
          if (hs && wb_count == TW'(TOTAL - 1)) begin
            state    <= S_DONE;
            img_done <= 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          wb_count <= '0;
        end
        default: state <= S_IDLE;
      endcase

      if (disp_en) begin
        eng_state[disp_eng]               <= ENG_BUSY;
        eng_start[disp_eng]               <= 1'b1;
        eng_blk_row[disp_eng*RW +: RW]    <= row_cnt;
        eng_blk_col[disp_eng*CW +: CW]    <= col_cnt;
        if (last_blk) begin
          row_cnt <= '0;
          col_cnt <= '0;
          state   <= S_DRAIN;
        end else if (col_cnt == CW'(NBC - 1)) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

endmodule
